// File: rtl/axi_rd_arbiter.sv
// Shares one AXI3 port between ICache (m0, reads) and DCache (m1, reads and writes).
// Reads are granted one burst at a time, round-robin; one write may be outstanding.
module axi_rd_arbiter #(
    parameter int LINE_BITS = 6,
    parameter int ID_W      = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [ID_W-1:0] m0_arid,
    input  logic [31:0]     m0_araddr,
    input  logic [3:0]      m0_arlen,
    input  logic [2:0]      m0_arsize,
    input  logic [1:0]      m0_arburst,
    input  logic            m0_arvalid,
    output logic            m0_arready,
    output logic [ID_W-1:0] m0_rid,
    output logic [31:0]     m0_rdata,
    output logic [1:0]      m0_rresp,
    output logic            m0_rlast,
    output logic            m0_rvalid,
    input  logic            m0_rready,
    input  logic [ID_W-1:0] m1_arid,
    input  logic [31:0]     m1_araddr,
    input  logic [3:0]      m1_arlen,
    input  logic [2:0]      m1_arsize,
    input  logic [1:0]      m1_arburst,
    input  logic            m1_arvalid,
    output logic            m1_arready,
    output logic [ID_W-1:0] m1_rid,
    output logic [31:0]     m1_rdata,
    output logic [1:0]      m1_rresp,
    output logic            m1_rlast,
    output logic            m1_rvalid,
    input  logic            m1_rready,
    input  logic [ID_W-1:0] m1_awid,
    input  logic [31:0]     m1_awaddr,
    input  logic [3:0]      m1_awlen,
    input  logic [2:0]      m1_awsize,
    input  logic [1:0]      m1_awburst,
    input  logic            m1_awvalid,
    output logic            m1_awready,
    input  logic [31:0]     m1_wdata,
    input  logic [3:0]      m1_wstrb,
    input  logic            m1_wlast,
    input  logic            m1_wvalid,
    output logic            m1_wready,
    output logic [ID_W-1:0] m1_bid,
    output logic [1:0]      m1_bresp,
    output logic            m1_bvalid,
    input  logic            m1_bready,
    output logic [ID_W-1:0] s_arid,
    output logic [31:0]     s_araddr,
    output logic [3:0]      s_arlen,
    output logic [2:0]      s_arsize,
    output logic [1:0]      s_arburst,
    output logic            s_arvalid,
    input  logic            s_arready,
    input  logic [ID_W-1:0] s_rid,
    input  logic [31:0]     s_rdata,
    input  logic [1:0]      s_rresp,
    input  logic            s_rlast,
    input  logic            s_rvalid,
    output logic            s_rready,
    output logic [ID_W-1:0] s_awid,
    output logic [31:0]     s_awaddr,
    output logic [3:0]      s_awlen,
    output logic [2:0]      s_awsize,
    output logic [1:0]      s_awburst,
    output logic            s_awvalid,
    input  logic            s_awready,
    output logic [ID_W-1:0] s_wid,
    output logic [31:0]     s_wdata,
    output logic [3:0]      s_wstrb,
    output logic            s_wlast,
    output logic            s_wvalid,
    input  logic            s_wready,
    input  logic [ID_W-1:0] s_bid,
    input  logic [1:0]      s_bresp,
    input  logic            s_bvalid,
    output logic            s_bready,
    output logic [1:0]      s_arlock,
    output logic [3:0]      s_arcache,
    output logic [2:0]      s_arprot,
    output logic [1:0]      s_awlock,
    output logic [3:0]      s_awcache,
    output logic [2:0]      s_awprot
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam int         LINE_W  = 32 - LINE_BITS;

    logic [1:0]        state_q, state_d;
    logic              grant_q, grant_d;
    logic              prio_q, prio_d;
    logic              wr_pend_q, wr_pend_d;
    logic [LINE_W-1:0] pend_line_q, pend_line_d;
    logic [ID_W-1:0]   awid_q, awid_d;
    logic              raw_hold_s, elig0_s, elig1_s, aw_hs_s, b_hs_s;

    // A DCache read to the line of the outstanding write must not overtake it.
    assign raw_hold_s = wr_pend_q && (m1_araddr[31:LINE_BITS] == pend_line_q);
    assign elig0_s    = m0_arvalid;
    assign elig1_s    = m1_arvalid && !raw_hold_s;
    assign aw_hs_s    = s_awvalid && s_awready;
    assign b_hs_s     = s_bvalid && s_bready;

    // Read arbitration FSM next state and round-robin priority.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        prio_d  = prio_q;
        case (state_q)
            ST_IDLE: begin
                if (elig0_s || elig1_s) begin
                    grant_d = (elig0_s && elig1_s) ? prio_q : elig1_s;
                    state_d = ST_ADDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (s_arvalid && s_arready) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (s_rvalid && s_rready && s_rlast) begin
                    state_d = ST_IDLE;
                    prio_d  = ~grant_q;
                end else begin
                    state_d = ST_DATA;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Read channel routing; routing follows grant, never rid.
    always_comb begin
        s_arid     = grant_q ? m1_arid    : m0_arid;
        s_araddr   = grant_q ? m1_araddr  : m0_araddr;
        s_arlen    = grant_q ? m1_arlen   : m0_arlen;
        s_arsize   = grant_q ? m1_arsize  : m0_arsize;
        s_arburst  = grant_q ? m1_arburst : m0_arburst;
        s_arvalid  = 1'b0;
        m0_arready = 1'b0;
        m1_arready = 1'b0;
        s_rready   = 1'b0;
        m0_rvalid  = 1'b0;
        m1_rvalid  = 1'b0;
        case (state_q)
            ST_ADDR: begin
                s_arvalid  = grant_q ? m1_arvalid : m0_arvalid;
                m0_arready = !grant_q && s_arready;
                m1_arready = grant_q && s_arready;
            end
            ST_DATA: begin
                s_rready  = grant_q ? m1_rready : m0_rready;
                m0_rvalid = !grant_q && s_rvalid;
                m1_rvalid = grant_q && s_rvalid;
            end
            default: begin
                s_arvalid = 1'b0;
            end
        endcase
    end

    assign m0_rid   = s_rid;
    assign m0_rdata = s_rdata;
    assign m0_rresp = s_rresp;
    assign m0_rlast = s_rlast;
    assign m1_rid   = s_rid;
    assign m1_rdata = s_rdata;
    assign m1_rresp = s_rresp;
    assign m1_rlast = s_rlast;

    // W and B only flow once AW has been accepted; a new AW waits for B.
    assign s_awid     = m1_awid;
    assign s_awaddr   = m1_awaddr;
    assign s_awlen    = m1_awlen;
    assign s_awsize   = m1_awsize;
    assign s_awburst  = m1_awburst;
    assign s_awvalid  = m1_awvalid && !wr_pend_q;
    assign m1_awready = s_awready && !wr_pend_q;
    assign s_wid      = awid_q;
    assign s_wdata    = m1_wdata;
    assign s_wstrb    = m1_wstrb;
    assign s_wlast    = m1_wlast;
    assign s_wvalid   = m1_wvalid && wr_pend_q;
    assign m1_wready  = s_wready && wr_pend_q;
    assign m1_bid     = s_bid;
    assign m1_bresp   = s_bresp;
    assign m1_bvalid  = s_bvalid && wr_pend_q;
    assign s_bready   = m1_bready && wr_pend_q;

    assign s_arlock  = 2'b00;
    assign s_arcache = 4'b0000;
    assign s_arprot  = 3'b000;
    assign s_awlock  = 2'b00;
    assign s_awcache = 4'b0000;
    assign s_awprot  = 3'b000;

    // Outstanding-write tracking; an AW handshake takes precedence over B.
    always_comb begin
        wr_pend_d   = wr_pend_q;
        pend_line_d = pend_line_q;
        awid_d      = awid_q;
        if (aw_hs_s) begin
            wr_pend_d   = 1'b1;
            pend_line_d = m1_awaddr[31:LINE_BITS];
            awid_d      = m1_awid;
        end else if (b_hs_s) begin
            wr_pend_d = 1'b0;
        end else begin
            wr_pend_d = wr_pend_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            grant_q     <= 1'b0;
            prio_q      <= 1'b0;
            wr_pend_q   <= 1'b0;
            pend_line_q <= '0;
            awid_q      <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            prio_q      <= prio_d;
            wr_pend_q   <= wr_pend_d;
            pend_line_q <= pend_line_d;
            awid_q      <= awid_d;
        end
    end

endmodule
